// File: rtl/parity_pkg.sv
// Shared types and constants for the parity arbiter slice.
package parity_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_arbiter_if.sv
// Requester / output handshake bundle for parity_arbiter.
interface parity_arbiter_if
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);

    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              odd_sel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_par;
    logic              out_src;

    modport master (
        output req0_valid, req0_data,
        output req1_valid, req1_data,
        output odd_sel, out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_par, out_src
    );

    modport slave (
        input  req0_valid, req0_data,
        input  req1_valid, req1_data,
        input  odd_sel, out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_par, out_src
    );

endinterface

// File: rtl/parity_generator.sv
// XOR reduction shared by both requesters.
module parity_generator #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] data,
    output logic              par
);

    assign par = ^data;

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin two-requester parity stage; grant counters under
// PARITY_ARBITER_GRANT_CNT_EN.
module parity_arbiter
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    parity_arbiter_if.slave  bus
`ifdef PARITY_ARBITER_GRANT_CNT_EN
    ,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
`endif
);

    out_state_t        state;
    logic              last_grant;
    logic              win0;
    logic              win1;
    logic              can_accept;
    logic              acc0;
    logic              acc1;
    logic              par;
    logic [DATA_W-1:0] gnt_data;

    always_comb begin
        win0 = bus.req0_valid & (~bus.req1_valid | last_grant);
        win1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
        can_accept = (state == EMPTY)
                   | (bus.out_ready & bus.out_valid);
        // Ready is forced low during reset so nothing is half-taken.
        bus.req0_ready = win0 & can_accept & ~rst;
        bus.req1_ready = win1 & can_accept & ~rst;
        acc0 = bus.req0_ready & bus.req0_valid;
        acc1 = bus.req1_ready & bus.req1_valid;
        gnt_data = win1 ? bus.req1_data : bus.req0_data;
    end

    parity_generator #(
        .DATA_W(DATA_W)
    ) u_par (
        .data(gnt_data),
        .par (par)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= EMPTY;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_par   <= 1'b0;
            bus.out_src   <= 1'b0;
            last_grant    <= 1'b1;
        end else if (acc0 | acc1) begin
            state         <= FULL;
            bus.out_valid <= 1'b1;
            bus.out_data  <= gnt_data;
            bus.out_par   <= par ^ bus.odd_sel;
            bus.out_src   <= acc1;
            last_grant    <= acc1;
        end else if (bus.out_ready && state == FULL) begin
            state         <= EMPTY;
            bus.out_valid <= 1'b0;
        end
    end

`ifdef PARITY_ARBITER_GRANT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (acc0 && cnt0 != 8'hFF)
                cnt0 <= cnt0 + 8'd1;
            if (acc1 && cnt1 != 8'hFF)
                cnt1 <= cnt1 + 8'd1;
        end
    end
`endif

endmodule
